// File: rtl/alu_exec_unit.sv
`default_nettype none
//==============================================================================
// Module : alu_exec_unit -- RISC-V ALU decode + execute, valid/ready handshake.
// Option : define ALU_EXEC_MUL_EN to add the iterative shift-add MUL path.
// Rev    : 1.0
//==============================================================================
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      op,
    output logic            zero,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] C_OP_AND  = 4'b0000;
    localparam logic [3:0] C_OP_OR   = 4'b0001;
    localparam logic [3:0] C_OP_ADD  = 4'b0010;
    localparam logic [3:0] C_OP_XOR  = 4'b0011;
    localparam logic [3:0] C_OP_SLL  = 4'b0100;
    localparam logic [3:0] C_OP_SRL  = 4'b0101;
    localparam logic [3:0] C_OP_SUB  = 4'b0110;
    localparam logic [3:0] C_OP_SRA  = 4'b0111;
    localparam logic [3:0] C_OP_SLT  = 4'b1000;
    localparam logic [3:0] C_OP_SLTU = 4'b1001;
    localparam logic [3:0] C_OP_ILL  = 4'b1111;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] C_OP_MUL  = 4'b1010;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [3:0]        op_q, op_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [SHW-1:0]    shamt;
    logic [3:0]        dec_op;
    logic [XLEN-1:0]   alu_res;
    logic              accept;
    logic              unused_instr_bits;

`ifdef ALU_EXEC_MUL_EN
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   acc_step;
    logic [SHW-1:0]    cnt_q, cnt_d;
`endif

    assign funct7            = instruction[31:25];
    assign funct3            = instruction[14:12];
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:0]};
    assign shamt             = op_b[SHW-1:0];

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign op        = op_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    always_comb begin
        dec_op = C_OP_ILL;
        case (aluop)
            2'b00: dec_op = C_OP_ADD;
            2'b01: dec_op = C_OP_SUB;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_op = C_OP_ADD;
                        3'b001:  dec_op = C_OP_SLL;
                        3'b010:  dec_op = C_OP_SLT;
                        3'b011:  dec_op = C_OP_SLTU;
                        3'b100:  dec_op = C_OP_XOR;
                        3'b101:  dec_op = C_OP_SRL;
                        3'b110:  dec_op = C_OP_OR;
                        default: dec_op = C_OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)
                        dec_op = C_OP_SUB;
                    else if (funct3 == 3'b101)
                        dec_op = C_OP_SRA;
                end
`ifdef ALU_EXEC_MUL_EN
                else if ((funct7 == 7'b0000001) && (funct3 == 3'b000)) begin
                    dec_op = C_OP_MUL;
                end
`endif
            end
            default: begin
                // Immediate forms: funct7 only qualifies the shift encodings.
                case (funct3)
                    3'b000: dec_op = C_OP_ADD;
                    3'b001: if (funct7 == 7'b0000000) dec_op = C_OP_SLL;
                    3'b010: dec_op = C_OP_SLT;
                    3'b011: dec_op = C_OP_SLTU;
                    3'b100: dec_op = C_OP_XOR;
                    3'b101: begin
                        if (funct7 == 7'b0000000)
                            dec_op = C_OP_SRL;
                        else if (funct7 == 7'b0100000)
                            dec_op = C_OP_SRA;
                    end
                    3'b110: dec_op = C_OP_OR;
                    default: dec_op = C_OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (dec_op)
            C_OP_AND:  alu_res = op_a & op_b;
            C_OP_OR:   alu_res = op_a | op_b;
            C_OP_ADD:  alu_res = op_a + op_b;
            C_OP_XOR:  alu_res = op_a ^ op_b;
            C_OP_SLL:  alu_res = op_a << shamt;
            C_OP_SRL:  alu_res = op_a >> shamt;
            C_OP_SUB:  alu_res = op_a - op_b;
            C_OP_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
            C_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            C_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:   alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        op_d      = op_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
`endif
        if (accept) begin
            op_d = dec_op;
`ifdef ALU_EXEC_MUL_EN
            if (dec_op == C_OP_MUL) begin
                state_d  = S_MUL;
                mcand_d  = op_a;
                mplier_d = op_b;
                acc_d    = '0;
                cnt_d    = '0;
            end else
`endif
            begin
                state_d   = S_DONE;
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                illegal_d = (dec_op == C_OP_ILL);
            end
        end else begin
            case (state_q)
                S_DONE: if (out_ready) state_d = S_IDLE;
`ifdef ALU_EXEC_MUL_EN
                S_MUL: begin
                    // One multiplier bit per cycle; the last step lands in DONE.
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SHW'(1);
                    if (cnt_q == SHW'(XLEN-1)) begin
                        state_d   = S_DONE;
                        result_d  = acc_step;
                        zero_d    = (acc_step == '0);
                        illegal_d = 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            op_q      <= 4'b0000;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            op_q      <= op_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
//==============================================================================
// Module : tb_alu_exec_unit -- directed self-checking bench for alu_exec_unit.
// Rev    : 1.0
//==============================================================================
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop;
    logic [31:0]     instruction;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [3:0]      op;
    logic            zero;
    logic            illegal;

    int n_pass  = 0;
    int n_total = 0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluop       (aluop),
        .instruction (instruction),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .op          (op),
        .zero        (zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t_aluop, input logic [31:0] t_instr,
                         input logic [XLEN-1:0] t_a, input logic [XLEN-1:0] t_b);
        aluop       = t_aluop;
        instruction = t_instr;
        op_a        = t_a;
        op_b        = t_b;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [XLEN-1:0] e_res,
                              input logic [3:0] e_op, input logic e_zero, input logic e_ill);
        check({tag, ".valid"},   64'(out_valid), 64'd1);
        check({tag, ".result"},  64'(result),    64'(e_res));
        check({tag, ".op"},      64'(op),        64'(e_op));
        check({tag, ".zero"},    64'(zero),      64'(e_zero));
        check({tag, ".illegal"}, 64'(illegal),   64'(e_ill));
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        aluop       = 2'b00;
        instruction = 32'h0;
        op_a        = '0;
        op_b        = '0;
        repeat (2) tick();
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result",    64'(result),    64'd0);
        check("rst.op",        64'(op),        64'd0);
        check("rst.zero",      64'(zero),      64'd0);
        check("rst.illegal",   64'(illegal),   64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;

        // ADD, latency one cycle
        issue(2'b10, 32'h007302B3, 32'd5, 32'd7);
        expect_out("add", 32'd12, 4'b0010, 1'b0, 1'b0);
        check("add.in_ready_held", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1 check("add.in_ready_done", 64'(in_ready), 64'd1);
        tick();
        out_ready = 1'b0;
        check("add.idle_valid", 64'(out_valid), 64'd0);

        // SUB to zero, held while consumer stalls
        issue(2'b10, 32'h407302B3, 32'd3, 32'd3);
        op_a = 32'd99;
        op_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            expect_out("sub_hold", 32'd0, 4'b0110, 1'b1, 1'b0);
            tick();
        end
        drain();

        issue(2'b10, 32'h40005033, 32'h80000000, 32'd4);
        expect_out("sra", 32'hF8000000, 4'b0111, 1'b0, 1'b0);
        drain();
        issue(2'b10, 32'h00005033, 32'h80000000, 32'd4);
        expect_out("srl", 32'h08000000, 4'b0101, 1'b0, 1'b0);
        drain();
        issue(2'b10, 32'h00002033, 32'hFFFFFFFF, 32'd1);
        expect_out("slt", 32'd1, 4'b1000, 1'b0, 1'b0);
        drain();
        issue(2'b10, 32'h00003033, 32'hFFFFFFFF, 32'd1);
        expect_out("sltu", 32'd0, 4'b1001, 1'b1, 1'b0);
        drain();
        issue(2'b10, 32'h00001033, 32'd1, 32'd33);
        expect_out("sll_mask", 32'd2, 4'b0100, 1'b0, 1'b0);
        drain();
        issue(2'b10, 32'h00004033, 32'h0000FF00, 32'h00000FF0);
        expect_out("xor", 32'h0000F0F0, 4'b0011, 1'b0, 1'b0);
        drain();
        issue(2'b10, 32'h40001033, 32'd7, 32'd9);
        expect_out("r_illegal", 32'd0, 4'b1111, 1'b1, 1'b1);
        drain();
        issue(2'b00, 32'h40005033, 32'hFFFFFFFF, 32'd2);
        expect_out("aluop00_wrap", 32'd1, 4'b0010, 1'b0, 1'b0);
        drain();
        issue(2'b01, 32'h00000000, 32'd0, 32'd1);
        expect_out("aluop01_sub", 32'hFFFFFFFF, 4'b0110, 1'b0, 1'b0);
        drain();
        issue(2'b11, 32'h00007013, 32'h0000F0F0, 32'h000000FF);
        expect_out("andi", 32'h000000F0, 4'b0000, 1'b0, 1'b0);
        drain();
        issue(2'b11, 32'hFE000013, 32'd1, 32'd2);
        expect_out("addi_f7_ignored", 32'd3, 4'b0010, 1'b0, 1'b0);
        drain();
        issue(2'b11, 32'h40001013, 32'd1, 32'd2);
        expect_out("slli_bad_f7", 32'd0, 4'b1111, 1'b1, 1'b1);
        drain();

        // MUL (or illegal when the multiplier is not built)
        issue(2'b10, 32'h02000033, 32'hFFFFFFFF, 32'd3);
`ifdef ALU_EXEC_MUL_EN
        check("mul.busy_valid", 64'(out_valid), 64'd0);
        check("mul.busy_ready", 64'(in_ready),  64'd0);
        check("mul.busy_op",    64'(op),        64'hA);
        aluop       = 2'b00;
        op_a        = 32'd100;
        op_b        = 32'd200;
        in_valid    = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("mul.latency", 64'(n), 64'd32);
        expect_out("mul", 32'hFFFFFFFD, 4'b1010, 1'b0, 1'b0);
`else
        expect_out("mul_absent", 32'd0, 4'b1111, 1'b1, 1'b1);
`endif
        drain();

        // Reset ten cycles into a MUL discards it
        issue(2'b10, 32'h02000033, 32'd6, 32'd7);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid", 64'(out_valid), 64'd0);
        check("rst_mid.op",        64'(op),        64'd0);
        check("rst_mid.result",    64'(result),    64'd0);
        #2 rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            tick();
            if (out_valid) n++;
        end
        check("rst_mid.no_valid", 64'(n), 64'd0);
        check("rst_mid.in_ready", 64'(in_ready), 64'd1);

        // Back-to-back ADDs with no bubble
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        aluop       = 2'b10;
        instruction = 32'h007302B3;
        op_a        = 32'd1;
        op_b        = 32'd1;
        tick();
        expect_out("b2b_1", 32'd2, 4'b0010, 1'b0, 1'b0);
        check("b2b.in_ready", 64'(in_ready), 64'd1);
        op_a = 32'd10;
        op_b = 32'd20;
        tick();
        expect_out("b2b_2", 32'd30, 4'b0010, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("b2b.idle", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept request.
REQ-006 SHALL have port aluop  input  2  main-control ALU class.
REQ-007 SHALL have port instruction  input  32  RISC-V instruction; funct7=[31:25], funct3=[14:12].
REQ-008 SHALL have ports op_a, op_b  input  XLEN  operands.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  XLEN  registered result.
REQ-012 SHALL have port op  output  4  registered decoded ALU operation.
REQ-013 SHALL have ports zero, illegal  output  1  result==0; undecodable request.

Function
REQ-014 SHALL decode op: aluop 00->0010 ADD; 01->0110 SUB; 10 R-type; 11 I-type (funct3 only; funct7 used only for shifts).
REQ-015 SHALL encode: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010, illegal 1111.
REQ-016 R-type: funct7 0000000 -> funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; funct7 0100000 with funct3 000 SUB, 101 SRA; other combinations illegal.
REQ-017 Shift amount SHALL be op_b[log2(XLEN)-1:0]; SLT signed, SLTU unsigned; ADD/SUB/MUL wrap modulo 2^XLEN (MUL returns low XLEN bits).
REQ-018 FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-019 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-020 Request accepted on edge with in_valid and in_ready; op, operands captured that edge.
REQ-021 Non-MUL op accepted at edge N: next state DONE, out_valid=1 from edge N (latency 1 cycle).
REQ-022 MUL accepted at edge N: state MUL, iterative shift-add one bit per cycle, DONE with out_valid=1 after edge N+XLEN.
REQ-023 In DONE, result/op/zero/illegal SHALL hold stable until out_ready=1; then IDLE, or re-accept if in_valid (back-to-back, no bubble).
REQ-024 Illegal decode SHALL complete as 1-cycle op: op=1111, result=0, zero=1, illegal=1.
REQ-025 in_valid during MUL SHALL be ignored (in_ready=0); operand changes during MUL SHALL not affect result.
REQ-026 zero and illegal SHALL be registered alongside result, valid only with out_valid.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, out_valid=0, result=0, op=0000, zero=0, illegal=0, MUL counter/accumulator=0.
REQ-028 Reset mid-MUL or in DONE SHALL discard the operation; no out_valid after release until a new request.
REQ-029 First accept possible on first rising edge with rst_n high.

Configuration
REQ-030 Macro ALU_EXEC_MUL_EN defined: MUL (R-type funct7 0000001, funct3 000) decoded per REQ-022.
REQ-031 Macro ALU_EXEC_MUL_EN undefined: MUL state and datapath absent; funct7 0000001 decodes illegal per REQ-024.

Verification
REQ-032 aluop=10, instruction=0x007302B3, op_a=5, op_b=7 -> op=0010, result=12, out_valid one cycle after accept.
REQ-033 aluop=10, instruction=0x407302B3, op_a=3, op_b=3 -> op=0110, result=0, zero=1; with out_ready=0 for 5 cycles outputs held.
REQ-034 aluop=10, funct7=0100000 funct3=101, op_a=0x80000000, op_b=4 -> op=0111, result=0xF8000000.
REQ-035 With ALU_EXEC_MUL_EN, funct7=0000001 funct3=000, op_a=0xFFFFFFFF, op_b=3 -> op=1010, result=0xFFFFFFFD, out_valid after 32 cycles; without macro -> illegal=1, op=1111, result=0 after 1 cycle.
REQ-036 rst_n pulsed low at cycle 10 of a MUL -> out_valid=0 immediately, state IDLE, in_ready=1 after release.
REQ-037 Two back-to-back ADDs with out_ready=1, in_valid held -> one result per cycle, no bubble.
